// File: rtl/otter_pkg.sv
// Shared OTTER pipeline types: base opcodes, forward-select encoding and
// the hazard controller state set, plus register-use decode helpers.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Bubble counts never exceed 3, so two bits always suffice.
    localparam int N_W = 2;

    function automatic logic uses_rs1(input opcode_t op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic uses_rs2(input opcode_t op);
        return (op == OP || op == BRANCH || op == STORE);
    endfunction

endpackage

// File: rtl/otter_hazard_detect.sv
// Combinational RAW check of the ID instruction against EX/MEM/WB producers;
// yields the bubble count and the select the instruction needs once it reaches EX.
module otter_hazard_detect
    import otter_pkg::*;
#(
    parameter int FWD_EN         = 1,
    parameter int REGFILE_BYPASS = 1,
    parameter int LOAD_LAT       = 1
) (
    input  logic [31:0]    id_ir,
    input  logic [4:0]     ex_rd,
    input  logic           ex_regwr,
    input  logic           ex_is_load,
    input  logic [4:0]     mem_rd,
    input  logic           mem_regwr,
    input  logic [4:0]     wb_rd,
    input  logic           wb_regwr,
    output logic [N_W-1:0] n,
    output fwd_sel_t       fwd_a,
    output fwd_sel_t       fwd_b
);

    opcode_t    op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_a;
    logic       use_b;
    logic       unused_ir_bits;
    logic       ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic       ex_hit, mem_hit, wb_hit;

    assign op             = opcode_t'(id_ir[6:0]);
    assign rs1            = id_ir[19:15];
    assign rs2            = id_ir[24:20];
    assign unused_ir_bits = ^{id_ir[31:25], id_ir[14:7]};
    assign use_a          = uses_rs1(op);
    assign use_b          = uses_rs2(op);

    // x0 is never a real producer, whatever the regwr flag claims.
    assign ex_a  = ex_regwr  && (ex_rd  != 5'd0) && use_a && (ex_rd  == rs1);
    assign ex_b  = ex_regwr  && (ex_rd  != 5'd0) && use_b && (ex_rd  == rs2);
    assign mem_a = mem_regwr && (mem_rd != 5'd0) && use_a && (mem_rd == rs1);
    assign mem_b = mem_regwr && (mem_rd != 5'd0) && use_b && (mem_rd == rs2);
    assign wb_a  = wb_regwr  && (wb_rd  != 5'd0) && use_a && (wb_rd  == rs1);
    assign wb_b  = wb_regwr  && (wb_rd  != 5'd0) && use_b && (wb_rd  == rs2);

    assign ex_hit  = ex_a  || ex_b;
    assign mem_hit = mem_a || mem_b;
    assign wb_hit  = wb_a  || wb_b;

    always_comb begin
        n = '0;
        if (FWD_EN != 0) begin
            if (ex_is_load && ex_hit) n = N_W'(LOAD_LAT);
        end else if (ex_hit) begin
            n = N_W'(3 - REGFILE_BYPASS);
        end else if (mem_hit) begin
            n = N_W'(2 - REGFILE_BYPASS);
        end else if (wb_hit) begin
            n = N_W'(1 - REGFILE_BYPASS);
        end
    end

    // Selects describe next cycle: today's EX producer sits in MEM, today's MEM one in WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_a)       fwd_a = FWD_MEM;
        else if (mem_a) fwd_a = FWD_WB;
        if (ex_b)       fwd_b = FWD_MEM;
        else if (mem_b) fwd_b = FWD_WB;
    end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER hazard controller: bubble-counter FSM, branch flush and registered
// forward selects driving the PC, IF/ID and ID/EX enables and clears.
module otter_hazard_ctrl
    import otter_pkg::*;
#(
    parameter int FWD_EN         = 1,
    parameter int REGFILE_BYPASS = 1,
    parameter int LOAD_LAT       = 1,
    parameter int CNT_W          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] id_ir,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwr,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwr,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwr,
    input  logic        br_taken,
    output logic        pc_write,
    output logic        if_id_en,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall_active
);

    logic [N_W-1:0]   n;
    fwd_sel_t         raw_a;
    fwd_sel_t         raw_b;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       fwd_a_nx, fwd_b_nx;
    logic             bubble;
    logic             advance;

    otter_hazard_detect #(
        .FWD_EN         (FWD_EN),
        .REGFILE_BYPASS (REGFILE_BYPASS),
        .LOAD_LAT       (LOAD_LAT)
    ) u_detect (
        .id_ir      (id_ir),
        .ex_rd      (ex_rd),
        .ex_regwr   (ex_regwr),
        .ex_is_load (ex_is_load),
        .mem_rd     (mem_rd),
        .mem_regwr  (mem_regwr),
        .wb_rd      (wb_rd),
        .wb_regwr   (wb_regwr),
        .n          (n),
        .fwd_a      (raw_a),
        .fwd_b      (raw_b)
    );

    // An external hold freezes state, counter and selects together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
        end else if (!hold) begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            fwd_a_sel <= fwd_a_nx;
            fwd_b_sel <= fwd_b_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bubble       = 1'b0;
        advance      = 1'b0;
        fwd_a_nx     = '0;
        fwd_b_nx     = '0;
        pc_write     = 1'b1;
        if_id_en     = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_clear  = 1'b0;
        stall_active = 1'b0;

        case (state)
            ST_RUN: begin
                if (n != '0) begin
                    bubble = 1'b1;
                    if (n > N_W'(1)) begin
                        state_nx = ST_STALL;
                        cnt_nx   = CNT_W'(n - N_W'(1));
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            ST_STALL: begin
                bubble = 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_FLUSH: state_nx = ST_RUN;
            default:  state_nx = ST_RUN;
        endcase

        if (bubble) begin
            pc_write     = 1'b0;
            if_id_en     = 1'b0;
            id_ex_clear  = 1'b1;
            stall_active = 1'b1;
        end

        // A taken branch squashes whatever ID holds, so pending bubbles are moot.
        if (br_taken) begin
            pc_write     = 1'b1;
            if_id_en     = 1'b1;
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            stall_active = 1'b0;
            state_nx     = ST_FLUSH;
            cnt_nx       = '0;
            advance      = 1'b0;
        end

        if (advance && (FWD_EN != 0)) begin
            fwd_a_nx = raw_a;
            fwd_b_nx = raw_b;
        end

        if (hold) begin
            pc_write     = 1'b0;
            if_id_en     = 1'b0;
            if_id_clear  = 1'b0;
            id_ex_clear  = 1'b0;
            stall_active = 1'b0;
        end

        if (rst) begin
            pc_write     = 1'b0;
            if_id_en     = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            stall_active = 1'b0;
        end
    end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: one forwarding instance and one
// stall-only instance share stimulus; each step is checked against hand values.
module tb_otter_hazard_ctrl;
    import otter_pkg::*;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [31:0] id_ir;
    logic [4:0]  ex_rd;
    logic        ex_regwr;
    logic        ex_is_load;
    logic [4:0]  mem_rd;
    logic        mem_regwr;
    logic [4:0]  wb_rd;
    logic        wb_regwr;
    logic        br_taken;

    logic        f_pc_write, f_if_id_en, f_if_id_clear, f_id_ex_clear, f_stall;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic        s_pc_write, s_if_id_en, s_if_id_clear, s_id_ex_clear, s_stall;
    logic [1:0]  s_fwd_a, s_fwd_b;

    logic [4:0]  ctl_f;
    logic [4:0]  ctl_s;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Control vector order: {pc_write, if_id_en, if_id_clear, id_ex_clear, stall_active}
    localparam logic [4:0] CTL_NORMAL = 5'b11000;
    localparam logic [4:0] CTL_BUBBLE = 5'b00011;
    localparam logic [4:0] CTL_RESET  = 5'b00110;

    assign ctl_f = {f_pc_write, f_if_id_en, f_if_id_clear, f_id_ex_clear, f_stall};
    assign ctl_s = {s_pc_write, s_if_id_en, s_if_id_clear, s_id_ex_clear, s_stall};

    otter_hazard_ctrl #(
        .FWD_EN(1), .REGFILE_BYPASS(1), .LOAD_LAT(1), .CNT_W(2)
    ) u_f (
        .clk(clk), .rst(rst), .hold(hold), .id_ir(id_ir),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .br_taken(br_taken), .pc_write(f_pc_write), .if_id_en(f_if_id_en),
        .if_id_clear(f_if_id_clear), .id_ex_clear(f_id_ex_clear),
        .fwd_a_sel(f_fwd_a), .fwd_b_sel(f_fwd_b), .stall_active(f_stall)
    );

    otter_hazard_ctrl #(
        .FWD_EN(0), .REGFILE_BYPASS(1), .LOAD_LAT(1), .CNT_W(2)
    ) u_s (
        .clk(clk), .rst(rst), .hold(hold), .id_ir(id_ir),
        .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
        .br_taken(br_taken), .pc_write(s_pc_write), .if_id_en(s_if_id_en),
        .if_id_clear(s_if_id_clear), .id_ex_clear(s_id_ex_clear),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b), .stall_active(s_stall)
    );

    // Free-running clock: posedges at 5, 15, ...; inputs change on negedges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, opc};
    endfunction

    function automatic logic [31:0] sw_ins(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction

    // Drives one cycle's worth of inputs on the negedge, then settles for sampling.
    task automatic applyStimulus(input logic [31:0] ir,
                                 input logic [4:0] exr, input logic exw, input logic exl,
                                 input logic [4:0] mr, input logic mw,
                                 input logic [4:0] wr, input logic ww,
                                 input logic br, input logic hd);
        @(negedge clk);
        id_ir      = ir;
        ex_rd      = exr;
        ex_regwr   = exw;
        ex_is_load = exl;
        mem_rd     = mr;
        mem_regwr  = mw;
        wb_rd      = wr;
        wb_regwr   = ww;
        br_taken   = br;
        hold       = hd;
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts the error and reports it.
    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic pulseReset(input string tag);
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_ctl_f"}, 8'(ctl_f), 8'(CTL_RESET));
        checkOutput({tag, "_rst_ctl_s"}, 8'(ctl_s), 8'(CTL_RESET));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Linear directed sequence; each block below is one scenario.
    initial begin
        rst = 1'b1; hold = 1'b0; id_ir = NOP; br_taken = 1'b0;
        ex_rd = '0; ex_regwr = 1'b0; ex_is_load = 1'b0;
        mem_rd = '0; mem_regwr = 1'b0; wb_rd = '0; wb_regwr = 1'b0;
        #2;
        checkOutput("init_ctl_f", 8'(ctl_f), 8'(CTL_RESET));
        checkOutput("init_fwd_f", 8'({f_fwd_a, f_fwd_b}), 8'd0);
        checkOutput("init_cnt_s", 8'(u_s.cnt), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // EX ALU producer feeding rs1: forwarding instance must not stall.
        applyStimulus(rtype(5'd6, 5'd5, 5'd3), 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("alu_fwd_ctl_f", 8'(ctl_f), 8'(CTL_NORMAL));
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("alu_fwd_sel_f", 8'({f_fwd_a, f_fwd_b}), 8'({2'd1, 2'd0}));

        // Load-use: one bubble, then the select points at WB once ID advances.
        pulseReset("ld");
        applyStimulus(rtype(5'd6, 5'd5, 5'd5), 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_bubble_f", 8'(ctl_f), 8'(CTL_BUBBLE));
        applyStimulus(rtype(5'd6, 5'd5, 5'd5), 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_adv_ctl_f", 8'(ctl_f), 8'(CTL_NORMAL));
        checkOutput("ld_bubble_sel_f", 8'({f_fwd_a, f_fwd_b}), 8'd0);
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_fwd_sel_f", 8'({f_fwd_a, f_fwd_b}), 8'({2'd2, 2'd2}));

        // Mixed producers: rs1 from EX (-> MEM sel), rs2 from MEM (-> WB sel).
        pulseReset("mix");
        applyStimulus(rtype(5'd8, 5'd9, 5'd10), 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("mix_ctl_f", 8'(ctl_f), 8'(CTL_NORMAL));
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mix_sel_f", 8'({f_fwd_a, f_fwd_b}), 8'({2'd1, 2'd2}));

        // x0 producer never hits, on either instance.
        pulseReset("x0");
        applyStimulus(rtype(5'd1, 5'd0, 5'd0), 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("x0_ctl_f", 8'(ctl_f), 8'(CTL_NORMAL));
        checkOutput("x0_ctl_s", 8'(ctl_s), 8'(CTL_NORMAL));
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("x0_sel_f", 8'({f_fwd_a, f_fwd_b}), 8'd0);

        // Field aliasing: LUI's rs1 bits and ADDI's rs2 bits are not register reads.
        applyStimulus(itype(7'b0110111, 5'd1, 5'd5, 12'h000), 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lui_no_use_s", 8'(ctl_s), 8'(CTL_NORMAL));
        applyStimulus(itype(7'b0010011, 5'd6, 5'd1, 12'd7), 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("addi_no_rs2_s", 8'(ctl_s), 8'(CTL_NORMAL));

        // Stall-only: EX producer for a store's rs2 gives exactly two bubbles.
        pulseReset("st");
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("st_b1_s", 8'(ctl_s), 8'(CTL_BUBBLE));
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("st_b2_s", 8'(ctl_s), 8'(CTL_BUBBLE));
        checkOutput("st_cnt1_s", 8'(u_s.cnt), 8'd1);
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("st_done_s", 8'(ctl_s), 8'(CTL_NORMAL));
        checkOutput("st_cnt0_s", 8'(u_s.cnt), 8'd0);
        checkOutput("st_sel_s", 8'({s_fwd_a, s_fwd_b}), 8'd0);

        // Branch in the first STALL cycle flushes and cancels the remaining bubble.
        pulseReset("br");
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("br_b1_s", 8'(ctl_s), 8'(CTL_BUBBLE));
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("br_flush_s", 8'({s_pc_write, s_if_id_clear, s_id_ex_clear, s_stall}), 8'(4'b1110));
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("br_flush_st_s", 8'(u_s.state), 8'(ST_FLUSH));
        checkOutput("br_cnt_s", 8'(u_s.cnt), 8'd0);
        checkOutput("br_nocheck_s", 8'(ctl_s), 8'(CTL_NORMAL));
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("br_run_s", 8'(ctl_s), 8'(CTL_NORMAL));
        checkOutput("br_run_st_s", 8'(u_s.state), 8'(ST_RUN));

        // Hold for three cycles mid-STALL: everything frozen, then the bubble resumes.
        pulseReset("hold");
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_b1_s", 8'(ctl_s), 8'(CTL_BUBBLE));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
            checkOutput("hold_ctl_s", 8'({s_pc_write, s_if_id_en, s_if_id_clear, s_id_ex_clear}), 8'd0);
            checkOutput("hold_cnt_s", 8'(u_s.cnt), 8'd1);
            checkOutput("hold_st_s", 8'(u_s.state), 8'(ST_STALL));
        end
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_resume_s", 8'(ctl_s), 8'(CTL_BUBBLE));
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_done_s", 8'(ctl_s), 8'(CTL_NORMAL));

        // Reset in the middle of a STALL drops the outstanding bubble.
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mrst_b1_s", 8'(ctl_s), 8'(CTL_BUBBLE));
        applyStimulus(sw_ins(5'd7, 5'd2), 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mrst_stall_s", 8'(u_s.state), 8'(ST_STALL));
        rst = 1'b1;
        #1;
        checkOutput("mrst_ctl_s", 8'(ctl_s), 8'(CTL_RESET));
        checkOutput("mrst_cnt_s", 8'(u_s.cnt), 8'd0);
        checkOutput("mrst_st_s", 8'(u_s.state), 8'(ST_RUN));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(NOP, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mrst_after_s", 8'(ctl_s), 8'(CTL_NORMAL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
